// File: rtl/fifo2clk_pkg.sv
// Shared definitions for the dual-clock FIFO read-side scheduler:
// FSM state encoding and small elaboration/arithmetic helpers.
package fifo2clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter and port width expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Smallest of three values; used to size a read burst.
    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fifo2clk_rrpick.sv
// Combinational round-robin picker: finds the first set bit of the
// eligible vector strictly after the pointer, wrapping around, with the
// pointer position itself searched last.
module fifo2clk_rrpick
    import fifo2clk_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]          elig,
    input  logic [clog2(NCH)-1:0]   ptr,
    output logic                    found,
    output logic [clog2(NCH)-1:0]   idx
);

    localparam int CHW = clog2(NCH);

    // Scan from the farthest position back to the nearest so the closest
    // eligible channel after the pointer is the last one written.
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = NCH; i >= 1; i--) begin
            k = (int'(ptr) + i) % NCH;
            if (elig[k]) begin
                found = 1'b1;
                idx   = CHW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo2clk_rdsched.sv
// Read-side scheduler for a bank of dual-clock FIFOs. Grants one channel
// at a time round-robin, issues a burst of reads bounded by MAXBURST, the
// channel fill level and downstream credits, sequences read-pointer
// flushes, and tags returning RAM data with its channel number.
module fifo2clk_rdsched
    import fifo2clk_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int ADDRB    = 4,
    parameter int MAXBURST = 8,
    parameter int CRED     = 16,
    parameter int RDLAT    = 2
) (
    input  logic                        rdclk,
    input  logic                        rdrst,
    input  logic [NCH-1:0]              fifonemp,
    input  logic [NCH*(ADDRB+1)-1:0]    rdfifolen,
    output logic [NCH-1:0]              fiford,
    output logic [NCH-1:0]              fifoflush,
    input  logic [NCH-1:0]              flushreq,
    output logic [NCH-1:0]              flushdone,
    input  logic                        crdret,
    output logic                        rdvld,
    output logic [clog2(NCH)-1:0]       rdch,
    output logic                        busy,
    output logic                        crderr
);

    localparam int CHW = clog2(NCH);
    localparam int LW  = ADDRB + 1;
    localparam int CW  = clog2(CRED + 1);
    localparam int BW  = clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CRED_V = CW'(CRED);

    state_t             state_q, state_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [BW-1:0]      rem_q, rem_d;
    logic [CHW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [NCH-1:0]     pend_q, pend_d;
    logic [NCH-1:0]     fiford_q, fiford_d;
    logic [NCH-1:0]     fifoflush_q, fifoflush_d;
    logic               crderr_q, crderr_d;
    logic               tag_vld_q [RDLAT];
    logic               tag_vld_d [RDLAT];
    logic [CHW-1:0]     tag_ch_q [RDLAT];
    logic [CHW-1:0]     tag_ch_d [RDLAT];

    logic [LW-1:0]      lvl [NCH];
    logic [NCH-1:0]     pend_all;
    logic [NCH-1:0]     elig;
    logic               pick_found;
    logic [CHW-1:0]     pick_idx;
    logic [CHW-1:0]     fl_idx;
    logic [CW-1:0]      grant_sub;
    int                 blen_i;

    // Unpack fill levels, merge new flush requests and find the lowest pending channel.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            lvl[k] = rdfifolen[k*LW +: LW];
        end
        pend_all = pend_q | flushreq;
        elig     = fifonemp & ~pend_all;
        fl_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend_all[k]) fl_idx = CHW'(k);
        end
    end

    fifo2clk_rrpick #(
        .NCH (NCH)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Burst length is fixed at grant time; the read side only sees the level grow.
    always_comb begin
        blen_i = min3(MAXBURST, int'(lvl[pick_idx]), int'(credit_q));
    end

    // Scheduler FSM: flushes take priority over grants, one bubble between operations.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rem_d       = rem_q;
        ptr_d       = ptr_q;
        pend_d      = pend_all;
        fiford_d    = '0;
        fifoflush_d = '0;
        grant_sub   = '0;
        case (state_q)
            IDLE: begin
                if (|pend_all) begin
                    state_d     = FLUSH;
                    ch_d        = fl_idx;
                    fifoflush_d = NCH'(1) << fl_idx;
                end else if (pick_found && blen_i != 0) begin
                    state_d   = BURST;
                    ch_d      = pick_idx;
                    rem_d     = BW'(blen_i);
                    ptr_d     = pick_idx;
                    grant_sub = CW'(blen_i);
                    fiford_d  = NCH'(1) << pick_idx;
                end
            end
            BURST: begin
                if (rem_q <= BW'(1)) begin
                    state_d = IDLE;
                end else begin
                    rem_d    = rem_q - 1'b1;
                    fiford_d = NCH'(1) << ch_q;
                end
            end
            FLUSH: begin
                // A request arriving during the flush cycle itself is kept.
                pend_d  = (pend_q & ~(NCH'(1) << ch_q)) | flushreq;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit accounting: grant and return apply net; a return at full credit is dropped and flagged.
    always_comb begin
        credit_d = credit_q - grant_sub;
        crderr_d = crderr_q;
        if (crdret) begin
            if (credit_q == CRED_V) crderr_d = 1'b1;
            else                    credit_d = credit_d + CW'(1);
        end
    end

    // Tag delay line matching the FIFO RAM read latency.
    always_comb begin
        tag_vld_d[0] = |fiford_q;
        tag_ch_d[0]  = (|fiford_q) ? ch_q : '0;
        for (int i = 1; i < RDLAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_ch_d[i]  = tag_ch_q[i-1];
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            rem_q       <= '0;
            ptr_q       <= CHW'(NCH - 1);
            credit_q    <= CRED_V;
            pend_q      <= '0;
            fiford_q    <= '0;
            fifoflush_q <= '0;
            crderr_q    <= 1'b0;
            for (int i = 0; i < RDLAT; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_ch_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rem_q       <= rem_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            pend_q      <= pend_d;
            fiford_q    <= fiford_d;
            fifoflush_q <= fifoflush_d;
            crderr_q    <= crderr_d;
            for (int i = 0; i < RDLAT; i++) begin
                tag_vld_q[i] <= tag_vld_d[i];
                tag_ch_q[i]  <= tag_ch_d[i];
            end
        end
    end

    assign fiford    = fiford_q;
    assign fifoflush = fifoflush_q;
    assign flushdone = fifoflush_q;
    assign crderr    = crderr_q;
    assign busy      = (state_q != IDLE);
    assign rdvld     = tag_vld_q[RDLAT-1];
    assign rdch      = tag_ch_q[RDLAT-1];

endmodule

// File: tb/tb_fifo2clk_rdsched.sv
// Bench for fifo2clk_rdsched: a FIFO-level environment, a transaction-level
// schedule model feeding expectation queues, and an independent monitor.
module tb_fifo2clk_rdsched;

    localparam int NCH      = 4;
    localparam int ADDRB    = 4;
    localparam int MAXBURST = 8;
    localparam int CRED     = 16;
    localparam int RDLAT    = 2;
    localparam int LW       = ADDRB + 1;
    localparam int CHW      = 2;
    localparam int NEVER    = 1 << 30;
    localparam int LVLMAX   = (1 << LW) - 1;

    logic                   rdclk = 1'b0;
    logic                   rdrst = 1'b0;
    logic [NCH-1:0]         fifonemp = '0;
    logic [NCH*LW-1:0]      rdfifolen = '0;
    logic [NCH-1:0]         fiford;
    logic [NCH-1:0]         fifoflush;
    logic [NCH-1:0]         flushreq = '0;
    logic [NCH-1:0]         flushdone;
    logic                   crdret = 1'b0;
    logic                   rdvld;
    logic [CHW-1:0]         rdch;
    logic                   busy;
    logic                   crderr;

    fifo2clk_rdsched #(
        .NCH(NCH), .ADDRB(ADDRB), .MAXBURST(MAXBURST), .CRED(CRED), .RDLAT(RDLAT)
    ) dut (
        .rdclk(rdclk), .rdrst(rdrst), .fifonemp(fifonemp), .rdfifolen(rdfifolen),
        .fiford(fiford), .fifoflush(fifoflush), .flushreq(flushreq), .flushdone(flushdone),
        .crdret(crdret), .rdvld(rdvld), .rdch(rdch), .busy(busy), .crderr(crderr)
    );

    always #5 rdclk = ~rdclk;

    int cyc = 0;
    always @(posedge rdclk) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; } ev_t;
    ev_t q_rd[$];
    ev_t q_tag[$];
    ev_t q_fl[$];

    int vectors = 0;
    int miscompares = 0;

    // environment: FIFO fill levels and stimulus knobs
    int             lvl [NCH];
    logic [NCH-1:0] last_rd = '0;
    logic [NCH-1:0] last_fl = '0;
    int             wr_pct = 0;
    int             crd_pct = 0;
    int             fl_pct = 0;

    // reference model state
    int             m_credit = CRED;
    int             m_ptr = NCH - 1;
    logic [NCH-1:0] m_pend = '0;
    int             m_idle_at = 0;
    int             m_busy_lo = 0;
    int             m_crderr_at = NEVER;

    task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_credit    = CRED;
        m_ptr       = NCH - 1;
        m_pend      = '0;
        m_idle_at   = 0;
        m_busy_lo   = 0;
        m_crderr_at = NEVER;
        q_rd.delete();
        q_tag.delete();
        q_fl.delete();
    endtask

    // Scheduling rules at transaction level: what happens in cycle T given this cycle's inputs.
    task automatic model_step(input logic [NCH-1:0] freq, input logic cr);
        int t, c0, sub, ch, blen;
        logic [NCH-1:0] pe;
        bit found;
        t   = cyc;
        c0  = m_credit;
        sub = 0;
        pe  = m_pend | freq;
        if (t >= m_idle_at) begin
            if (pe != '0) begin
                ch = 0;
                while (!pe[ch]) ch++;
                q_fl.push_back('{t + 1, ch});
                pe[ch]    = 1'b0;
                m_busy_lo = t + 1;
                m_idle_at = t + 2;
            end else if (c0 > 0) begin
                found = 0;
                ch    = 0;
                for (int i = 1; i <= NCH && !found; i++) begin
                    ch = (m_ptr + i) % NCH;
                    if (lvl[ch] > 0) found = 1;
                end
                if (found) begin
                    blen = MAXBURST;
                    if (lvl[ch] < blen) blen = lvl[ch];
                    if (c0 < blen) blen = c0;
                    for (int j = 1; j <= blen; j++) begin
                        q_rd.push_back('{t + j, ch});
                        q_tag.push_back('{t + j + RDLAT, ch});
                    end
                    sub       = blen;
                    m_ptr     = ch;
                    m_busy_lo = t + 1;
                    m_idle_at = t + blen + 1;
                end
            end
        end
        m_pend = pe;
        if (cr && c0 == CRED) begin
            if (m_crderr_at == NEVER) m_crderr_at = t + 1;
            m_credit = c0 - sub;
        end else begin
            m_credit = c0 - sub + (cr ? 1 : 0);
        end
    endtask

    // Apply last cycle's reads/flushes to the FIFO levels, add random writes, drive inputs, run the model.
    task automatic cycle_body(input logic [NCH-1:0] freq, input logic cr);
        int k;
        for (int i = 0; i < NCH; i++) begin
            if (last_fl[i])                 lvl[i] = 0;
            else if (last_rd[i] && lvl[i] > 0) lvl[i] = lvl[i] - 1;
        end
        if (wr_pct > 0 && $urandom_range(99) < wr_pct) begin
            k = $urandom_range(NCH - 1);
            if (lvl[k] < LVLMAX) lvl[k] = lvl[k] + 1;
        end
        for (int i = 0; i < NCH; i++) begin
            fifonemp[i]             = (lvl[i] > 0);
            rdfifolen[i*LW +: LW]   = LW'(lvl[i]);
        end
        flushreq = freq;
        crdret   = cr;
        model_step(freq, cr);
        last_rd = fiford;
        last_fl = fifoflush;
    endtask

    task automatic one(input logic [NCH-1:0] freq, input logic cr);
        @(posedge rdclk);
        #1;
        cycle_body(freq, cr);
    endtask

    task automatic run(input int n);
        logic [NCH-1:0] freq;
        logic cr;
        for (int i = 0; i < n; i++) begin
            freq = '0;
            if (fl_pct > 0 && $urandom_range(99) < fl_pct)
                freq[$urandom_range(NCH - 1)] = 1'b1;
            cr = (crd_pct > 0 && $urandom_range(99) < crd_pct);
            one(freq, cr);
        end
    endtask

    // Assert reset (mid-cycle), confirm outputs drop at once, then release into a normal cycle.
    task automatic do_reset(input bit wait_edge);
        if (wait_edge) begin
            @(posedge rdclk);
            #1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (last_fl[i])                 lvl[i] = 0;
            else if (last_rd[i] && lvl[i] > 0) lvl[i] = lvl[i] - 1;
        end
        last_rd  = '0;
        last_fl  = '0;
        flushreq = '0;
        crdret   = 1'b0;
        rdrst    = 1'b1;
        model_reset();
        #1;
        chk("rst_fiford", fiford == '0, fiford, 0);
        chk("rst_rdvld", rdvld == 1'b0, rdvld, 0);
        chk("rst_fifoflush", fifoflush == '0, fifoflush, 0);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_crderr", crderr == 1'b0, crderr, 0);
        chk("rst_rdch", rdch == '0, rdch, 0);
        repeat (3) @(posedge rdclk);
        #1;
        rdrst = 1'b0;
        cycle_body('0, 1'b0);
    endtask

    // Monitor: compare every presented output against the expectation queues and model flags.
    always @(negedge rdclk) begin
        ev_t e;
        if (fiford != '0) begin
            if (q_rd.size() == 0) begin
                chk("fiford_unexpected", 1'b0, fiford, 0);
            end else begin
                e = q_rd.pop_front();
                chk("fiford_cycle", cyc == e.cyc, cyc, e.cyc);
                chk("fiford_onehot", fiford == (NCH'(1) << e.ch), fiford, 1 << e.ch);
            end
        end else if (q_rd.size() > 0 && q_rd[0].cyc <= cyc) begin
            e = q_rd.pop_front();
            chk("fiford_missing", 1'b0, 0, e.ch);
        end
        if (rdvld) begin
            if (q_tag.size() == 0) begin
                chk("rdvld_unexpected", 1'b0, rdch, 0);
            end else begin
                e = q_tag.pop_front();
                chk("rdvld_cycle", cyc == e.cyc, cyc, e.cyc);
                chk("rdch", int'(rdch) == e.ch, rdch, e.ch);
            end
        end else if (q_tag.size() > 0 && q_tag[0].cyc <= cyc) begin
            e = q_tag.pop_front();
            chk("rdvld_missing", 1'b0, 0, e.ch);
        end
        if (fifoflush != '0) begin
            if (q_fl.size() == 0) begin
                chk("flush_unexpected", 1'b0, fifoflush, 0);
            end else begin
                e = q_fl.pop_front();
                chk("flush_cycle", cyc == e.cyc, cyc, e.cyc);
                chk("flush_onehot", fifoflush == (NCH'(1) << e.ch), fifoflush, 1 << e.ch);
            end
        end else if (q_fl.size() > 0 && q_fl[0].cyc <= cyc) begin
            e = q_fl.pop_front();
            chk("flush_missing", 1'b0, 0, e.ch);
        end
        chk("flushdone", flushdone == fifoflush, flushdone, fifoflush);
        chk("busy", busy == (cyc >= m_busy_lo && cyc < m_idle_at), busy,
            (cyc >= m_busy_lo && cyc < m_idle_at));
        chk("crderr", crderr == (cyc >= m_crderr_at), crderr, (cyc >= m_crderr_at));
    end

    initial begin
        for (int i = 0; i < NCH; i++) lvl[i] = 0;
        #1;
        do_reset(1'b0);

        // single channel, level 5: one burst of 5, credit 16 -> 11
        lvl[0] = 5;
        run(20);

        // all channels deep, credits streaming back: round-robin 0,1,2,3,0...
        crd_pct = 100;
        for (int i = 0; i < NCH; i++) lvl[i] = 20;
        run(50);

        // reset in the middle of activity, then credit starvation on two channels
        crd_pct = 0;
        lvl[0] = 20; lvl[1] = 20; lvl[2] = 0; lvl[3] = 0;
        do_reset(1'b1);
        run(30);
        one('0, 1'b1);
        run(15);

        // flush of channel 2 requested while channel 2 bursts; channel 3 waits behind it
        lvl[0] = 0; lvl[1] = 0; lvl[2] = 20; lvl[3] = 20;
        do_reset(1'b1);
        run(3);
        one(4'b0100, 1'b0);
        run(30);

        // credit returned at full credit: sticky error
        for (int i = 0; i < NCH; i++) lvl[i] = 0;
        do_reset(1'b1);
        run(2);
        one('0, 1'b1);
        run(3);
        lvl[1] = 20;
        run(12);

        // randomized traffic
        for (int i = 0; i < NCH; i++) lvl[i] = $urandom_range(LVLMAX);
        do_reset(1'b1);
        wr_pct = 40; crd_pct = 15; fl_pct = 3;
        run(3000);

        // drain
        wr_pct = 0; crd_pct = 0; fl_pct = 0;
        for (int i = 0; i < NCH; i++) lvl[i] = 0;
        run(MAXBURST + RDLAT + 10);

        chk("rd_queue_drained", q_rd.size() == 0, q_rd.size(), 0);
        chk("tag_queue_drained", q_tag.size() == 0, q_tag.size(), 0);
        chk("flush_queue_drained", q_fl.size() == 0, q_fl.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo2clk_rdsched.md
# fifo2clk_rdsched

Read-side scheduler for a bank of NCH dual-clock gray-pointer FIFOs, all in the rdclk domain. Watches each FIFO's not-empty flag and fill level, grants one channel at a time round-robin, and drives that channel's read enable for a precomputed burst, bounded by MAXBURST and downstream credits. Also sequences per-channel read-side flushes and tags returning read data with its channel number and a valid strobe.

## Interface
- NCH, 4: number of FIFO channels (2..16)
- ADDRB, 4: FIFO address bits; fill level is ADDRB+1 bits
- MAXBURST, 8: max reads per grant (1..2^ADDRB)
- CRED, 16: downstream buffer depth in entries
- RDLAT, 2: FIFO RAM read latency, rdaddr to data (1..4)

Ports:
- rdclk  in  1  clock
- rdrst  in  1  reset; asynchronous, active-high
- fifonemp  in  NCH  per-channel not-empty
- rdfifolen  in  NCH*(ADDRB+1)  per-channel fill level; channel k at bits [k*(ADDRB+1) +: ADDRB+1]
- fiford  out  NCH  one-hot read request, registered
- fifoflush  out  NCH  one-hot read-pointer flush pulse, registered
- flushreq  in  NCH  flush request pulses, one cycle each
- flushdone  out  NCH  one-cycle ack, same cycle as fifoflush
- crdret  in  1  one downstream credit returned
- rdvld  out  1  read data valid at FIFO RAM output
- rdch  out  clog2(NCH)  channel of the data under rdvld
- busy  out  1  state != IDLE
- crderr  out  1  sticky: credit returned while counter == CRED

## Operation
- Reset values: all outputs 0. Credit counter = CRED. Round-robin pointer = NCH-1, so channel 0 is searched first. Flush-pending vector cleared.
- flushreq bits OR into the pending vector every cycle, including during BURST and FLUSH.
- A channel is eligible when fifonemp[k]=1 and pending[k]=0.
- IDLE, evaluated in this priority order:
  - Any pending bit set: take the lowest pending index, go to FLUSH.
  - Else, if any channel is eligible and credit > 0: grant the first eligible channel after the pointer, circularly. Latch ch and blen = min(MAXBURST, rdfifolen[ch], credit). Subtract blen from credit. Set pointer = ch. Go to BURST.
  - Else stay in IDLE.
- BURST: fiford[ch]=1 for exactly blen consecutive cycles, then IDLE. fifonemp and rdfifolen are not re-checked; the read side only ever sees the level grow, so the latched blen is safe.
- FLUSH: one cycle with fifoflush[ch]=1 and flushdone[ch]=1. Clear pending[ch], then IDLE. The round-robin pointer is unchanged.
- Credit counter:
  - Next value = credit − (grant ? blen : 0) + crdret; simultaneous events apply net.
  - Width is clog2(CRED+1); never exceeds CRED.
  - crdret at CRED is dropped and sets crderr.
- Tag pipeline: RDLAT-deep shift of {|fiford, ch}. rdvld/rdch = shift-register output.
- Async reset mid-BURST: outputs drop immediately; in-flight rdvld is discarded.

## Timing
- Grant decision in IDLE at cycle T; fiford asserted T+1..T+blen; back in IDLE at T+blen+1.
- One bubble between consecutive bursts, so rdfifolen already reflects the previous burst's pointer update when the next grant is computed.
- rdvld for the read issued in cycle t is high at t+RDLAT.
- Flush: a request in cycle T, with the FSM in IDLE, gives FLUSH at T+1 and fifoflush at T+1 (registered off the next state). If requested during a burst, the flush waits for the burst to end.
- Flush for channel k never overlaps fiford[k].

## Structure
- Shared package fifo2clk_pkg holds:
  - state encoding: IDLE=2'd0, BURST=2'd1, FLUSH=2'd2
  - clog2 function
  - min helper for blen
- One sub-module, fifo2clk_rrpick:
  - combinational round-robin first-one finder
  - inputs: eligible vector, pointer
  - outputs: found, index
- Tag delay line is inline.

## Test plan
- Single channel, rdfifolen[0]=5, CRED=16 -> fiford[0] high 5 cycles; credit becomes 11; rdvld 5 cycles starting RDLAT after the first fiford, rdch=0.
- Channels 0..3 all at level 20, crdret held high -> grants go 0,1,2,3,0 with 8 reads each and a 1-cycle gap; no channel granted twice before the others.
- Credit starvation: CRED=16, levels 20/20, no crdret -> bursts of 8 then 8; no further grant until crdret; a single crdret pulse then yields blen=1.
- flushreq[2] pulsed mid-burst on channel 2 -> burst completes; fifoflush[2]/flushdone[2] for 1 cycle after the bubble; channel 2 skipped while pending.
- crdret pulsed with credit=CRED -> crderr=1 and stays set; credit remains 16.
- rdrst asserted during BURST -> fiford=0, rdvld=0 immediately; after release, credit=16 and channel 0 is granted first.
